spo2_valfmt: RTL
================

# spo2_valfmt

Producer side of the LCD value interface in the SpO2 demo. Takes binary SpO2, heart-rate and power results from the measurement pipeline and converts them to packed BCD with a sequential double-dabble engine. Issues the update to the LCD driver as one `VAL_SPO2`/`VAL_HEARTRATE`/`VAL_WATT` set qualified by a single-cycle `VAL_STB`, and only while the driver reports idle. Sits between the SpO2/HR calculation block and `lcddrive`.

## Interface
- `LCD_WAIT_MAX`, default 0: maximum number of cycles to wait for `LCD_IDLE` before strobing anyway. 0 means wait forever.
- `CLK`  in  1  system clock; all logic on the rising edge.
- `XRST`  in  1  reset; asynchronous and active-low.
- `IN_SPO2`  in  10  binary SpO2 (%).
- `IN_HEARTRATE`  in  10  binary heart rate (bpm).
- `IN_WATT`  in  17  binary power value.
- `IN_STB`  in  1  one-cycle strobe; IN_* are valid on this cycle.
- `LCD_IDLE`  in  1  high while the LCD driver is in its main idle state.
- `BUSY`  out  1  high from IN_STB capture until VAL_STB is issued.
- `VAL_SPO2`  out  12  3-digit packed BCD.
- `VAL_HEARTRATE`  out  12  3-digit packed BCD.
- `VAL_WATT`  out  20  5-digit packed BCD.
- `VAL_STB`  out  1  one-cycle update strobe to the LCD driver.
- `VAL_SAT`  out  1  at least one field of the current VAL_* set was clamped.

## Operation
- States: IDLE, CONV, WAIT, STRB.
- IDLE: on `IN_STB`=1, capture the clamped operands, clear the BCD accumulators and step counter, set `BUSY`, go to CONV.
  - `IN_SPO2`/`IN_HEARTRATE` > 999 are clamped to 999.
  - `IN_WATT` > 99999 is clamped to 99999.
  - The SAT flag is set if any field was clamped.
- CONV: exactly 17 double-dabble steps, one per cycle, with all three fields processed in parallel.
  - The 10-bit fields are zero-extended on the MSB side to 17 bits.
  - Each step first adds 3 to every BCD digit ≥5, then shifts one operand bit in (MSB first).
  - After step 17, go to WAIT.
- WAIT: when `LCD_IDLE`=1, go to STRB. If `LCD_WAIT_MAX`≠0 and `LCD_WAIT_MAX` cycles have elapsed in WAIT, go to STRB regardless of `LCD_IDLE`.
- STRB: load VAL_* and `VAL_SAT` from the accumulators, pulse `VAL_STB` high, clear `BUSY`, return to IDLE.
- VAL_* and `VAL_SAT` hold their value between strobes.
- `IN_STB` while `BUSY`: handling is set by the configuration macro below.
- An `IN_STB` coinciding with the STRB cycle counts as busy.
- Reset (`XRST`=0), at any time including mid-CONV/WAIT:
  - All outputs go to 0 (`VAL_*`=0, `VAL_STB`=0, `BUSY`=0, `VAL_SAT`=0).
  - State goes to IDLE; counters and any pending capture are cleared.
  - The conversion in flight is discarded and no strobe is emitted.

## Timing
- `IN_STB` is sampled on edge N. CONV steps occur on edges N+1 … N+17.
- With `LCD_IDLE` already high, `VAL_STB`=1 and the new VAL_* appear after edge N+19. This 19-cycle latency is the minimum.
- `VAL_STB` is high for exactly one cycle. VAL_* are stable on and after that cycle.
- `BUSY` rises after edge N and falls in the same cycle that `VAL_STB` is high.
- WAIT adds k cycles if `LCD_IDLE` rises k cycles late.
- The `LCD_WAIT_MAX` timeout fires after exactly `LCD_WAIT_MAX` cycles in WAIT.
- Back-to-back throughput: one update per 20 cycles (IDLE cycle included).

## Configuration
- `SPO2_VALFMT_PENDING_EN` defined:
  - A one-deep pending register captures `IN_STB` while `BUSY`, overwriting any earlier pending set so the newest wins.
  - After STRB, a pending set starts CONV on the next edge without passing through IDLE. `BUSY` then stays high.
- `SPO2_VALFMT_PENDING_EN` undefined:
  - `IN_STB` while `BUSY` is ignored.
  - No pending register is built.

## Test plan
- Nominal: SPO2=97, HR=55, WATT=54321, `LCD_IDLE`=1 → after 19 cycles, `VAL_SPO2`=12'h097, `VAL_HEARTRATE`=12'h055, `VAL_WATT`=20'h54321, one-cycle `VAL_STB`, `VAL_SAT`=0.
- Saturation: SPO2=1023, HR=0, WATT=131071 → 12'h999, 12'h000, 20'h99999, `VAL_SAT`=1. Boundary 999/99999 gives the same digits with `VAL_SAT`=0.
- LCD busy: hold `LCD_IDLE`=0 for 30 cycles after CONV, `LCD_WAIT_MAX`=0 → `VAL_STB` waits until 1 cycle after `LCD_IDLE` rises. With `LCD_WAIT_MAX`=8 → `VAL_STB` fires 8 cycles into WAIT.
- Overlap: second `IN_STB` (SPO2=98) at N+5.
  - Macro off: only the first set is strobed.
  - Macro on: a second `VAL_STB` with 12'h098 arrives 18 cycles after the first.
- Reset at N+10: `XRST` pulsed low → all outputs 0 immediately and no `VAL_STB`. A new `IN_STB` after release converts normally.

Source files
------------

// File: rtl/spo2_valfmt_if.sv
// rtl/spo2_valfmt_if.sv - measurement-result input and LCD value output bundle for spo2_valfmt
interface spo2_valfmt_if;
    logic [9:0]  IN_SPO2;
    logic [9:0]  IN_HEARTRATE;
    logic [16:0] IN_WATT;
    logic        IN_STB;
    logic        LCD_IDLE;
    logic        BUSY;
    logic [11:0] VAL_SPO2;
    logic [11:0] VAL_HEARTRATE;
    logic [19:0] VAL_WATT;
    logic        VAL_STB;
    logic        VAL_SAT;

    modport master (
        output IN_SPO2, IN_HEARTRATE, IN_WATT, IN_STB, LCD_IDLE,
        input  BUSY, VAL_SPO2, VAL_HEARTRATE, VAL_WATT, VAL_STB, VAL_SAT
    );

    modport slave (
        input  IN_SPO2, IN_HEARTRATE, IN_WATT, IN_STB, LCD_IDLE,
        output BUSY, VAL_SPO2, VAL_HEARTRATE, VAL_WATT, VAL_STB, VAL_SAT
    );
endinterface

// File: rtl/spo2_valfmt.sv
// rtl/spo2_valfmt.sv - binary-to-BCD formatter and strobe issuer for the LCD value interface
// Optional one-deep pending capture while busy: define SPO2_VALFMT_PENDING_EN.
module spo2_valfmt #(
    parameter int unsigned LCD_WAIT_MAX = 0
) (
    input  logic          CLK,
    input  logic          XRST,
    spo2_valfmt_if.slave  vif
);
    typedef enum logic [1:0] {IDLE, CONV, WAIT, STRB} state_t;

    state_t      state, state_nxt;
    logic        load, step, restart, restart_go;
    logic [4:0]  step_cnt;
    logic [31:0] wait_cnt;
    logic [16:0] op_spo2, op_hr, op_watt;
    logic [11:0] acc_spo2, acc_hr;
    logic [19:0] acc_watt;
    logic        sat_acc;
    logic [16:0] cl_spo2, cl_hr, cl_watt;
    logic        cl_sat;
    logic [16:0] rs_spo2, rs_hr, rs_watt;
    logic        rs_sat;
    logic [11:0] val_spo2, val_hr;
    logic [19:0] val_watt;
    logic        val_stb, val_sat;

    function automatic logic [11:0] dd_step12(input logic [11:0] acc, input logic b);
        logic [11:0] t;
        t = acc;
        for (int d = 0; d < 3; d++)
            if (t[d*4 +: 4] >= 4'd5) t[d*4 +: 4] = t[d*4 +: 4] + 4'd3;
        return {t[10:0], b};
    endfunction

    function automatic logic [19:0] dd_step20(input logic [19:0] acc, input logic b);
        logic [19:0] t;
        t = acc;
        for (int d = 0; d < 5; d++)
            if (t[d*4 +: 4] >= 4'd5) t[d*4 +: 4] = t[d*4 +: 4] + 4'd3;
        return {t[18:0], b};
    endfunction

    always_comb begin
        cl_spo2 = (vif.IN_SPO2 > 10'd999)      ? 17'd999   : {7'd0, vif.IN_SPO2};
        cl_hr   = (vif.IN_HEARTRATE > 10'd999) ? 17'd999   : {7'd0, vif.IN_HEARTRATE};
        cl_watt = (vif.IN_WATT > 17'd99999)    ? 17'd99999 : vif.IN_WATT;
        cl_sat  = (vif.IN_SPO2 > 10'd999) || (vif.IN_HEARTRATE > 10'd999)
                  || (vif.IN_WATT > 17'd99999);
    end

`ifdef SPO2_VALFMT_PENDING_EN
    logic        pend_vld;
    logic [16:0] pend_spo2, pend_hr, pend_watt;
    logic        pend_sat;

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            pend_vld  <= 1'b0;
            pend_spo2 <= '0;
            pend_hr   <= '0;
            pend_watt <= '0;
            pend_sat  <= 1'b0;
        end else if (restart_go) begin
            pend_vld <= 1'b0;
        end else if (vif.IN_STB && state != IDLE) begin
            pend_vld  <= 1'b1;
            pend_spo2 <= cl_spo2;
            pend_hr   <= cl_hr;
            pend_watt <= cl_watt;
            pend_sat  <= cl_sat;
        end
    end

    // A strobe landing on the STRB cycle is newer than anything pending.
    assign restart = vif.IN_STB | pend_vld;
    assign rs_spo2 = vif.IN_STB ? cl_spo2 : pend_spo2;
    assign rs_hr   = vif.IN_STB ? cl_hr   : pend_hr;
    assign rs_watt = vif.IN_STB ? cl_watt : pend_watt;
    assign rs_sat  = vif.IN_STB ? cl_sat  : pend_sat;
`else
    assign restart = 1'b0;
    assign rs_spo2 = cl_spo2;
    assign rs_hr   = cl_hr;
    assign rs_watt = cl_watt;
    assign rs_sat  = cl_sat;
`endif

    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        step       = 1'b0;
        restart_go = 1'b0;
        case (state)
            IDLE: if (vif.IN_STB) begin
                load      = 1'b1;
                state_nxt = CONV;
            end
            CONV: begin
                step = 1'b1;
                if (step_cnt == 5'd16) state_nxt = WAIT;
            end
            WAIT: if (vif.LCD_IDLE || (LCD_WAIT_MAX != 0 && wait_cnt == LCD_WAIT_MAX - 1))
                state_nxt = STRB;
            STRB: if (restart) begin
                restart_go = 1'b1;
                state_nxt  = CONV;
            end else begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A restart out of STRB folds the first dabble step into the capture edge.
    always_ff @(posedge CLK or negedge XRST) begin
        if (!XRST) begin
            step_cnt <= '0;
            wait_cnt <= '0;
            op_spo2  <= '0;
            op_hr    <= '0;
            op_watt  <= '0;
            acc_spo2 <= '0;
            acc_hr   <= '0;
            acc_watt <= '0;
            sat_acc  <= 1'b0;
            val_spo2 <= '0;
            val_hr   <= '0;
            val_watt <= '0;
            val_stb  <= 1'b0;
            val_sat  <= 1'b0;
        end else begin
            val_stb  <= 1'b0;
            wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : 32'd0;
            if (load) begin
                op_spo2  <= cl_spo2;
                op_hr    <= cl_hr;
                op_watt  <= cl_watt;
                sat_acc  <= cl_sat;
                acc_spo2 <= '0;
                acc_hr   <= '0;
                acc_watt <= '0;
                step_cnt <= '0;
            end else if (step) begin
                acc_spo2 <= dd_step12(acc_spo2, op_spo2[16]);
                acc_hr   <= dd_step12(acc_hr, op_hr[16]);
                acc_watt <= dd_step20(acc_watt, op_watt[16]);
                op_spo2  <= {op_spo2[15:0], 1'b0};
                op_hr    <= {op_hr[15:0], 1'b0};
                op_watt  <= {op_watt[15:0], 1'b0};
                step_cnt <= step_cnt + 5'd1;
            end
            if (state == STRB) begin
                val_spo2 <= acc_spo2;
                val_hr   <= acc_hr;
                val_watt <= acc_watt;
                val_sat  <= sat_acc;
                val_stb  <= 1'b1;
                if (restart_go) begin
                    op_spo2  <= {rs_spo2[15:0], 1'b0};
                    op_hr    <= {rs_hr[15:0], 1'b0};
                    op_watt  <= {rs_watt[15:0], 1'b0};
                    acc_spo2 <= {11'd0, rs_spo2[16]};
                    acc_hr   <= {11'd0, rs_hr[16]};
                    acc_watt <= {19'd0, rs_watt[16]};
                    sat_acc  <= rs_sat;
                    step_cnt <= 5'd1;
                end
            end
        end
    end

    assign vif.BUSY          = (state != IDLE);
    assign vif.VAL_SPO2      = val_spo2;
    assign vif.VAL_HEARTRATE = val_hr;
    assign vif.VAL_WATT      = val_watt;
    assign vif.VAL_STB       = val_stb;
    assign vif.VAL_SAT       = val_sat;
endmodule
